// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry, speeds, colours and state encodings for the Pong pixel generator.
package pong_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  localparam logic [15:0] WALL_L   = 16'd32;
  localparam logic [15:0] WALL_R   = 16'd39;
  localparam logic [15:0] PAD_L    = 16'd760;
  localparam logic [15:0] PAD_R    = 16'd767;
  localparam logic [15:0] PAD_EXT  = 16'd95;
  localparam logic [15:0] BALL_EXT = 16'd7;
  localparam logic [9:0]  BALL_X0  = 10'd396;
  localparam logic [9:0]  BALL_Y0  = 10'd296;
  localparam logic [9:0]  PAD_Y0   = 10'd252;
  localparam logic [9:0]  PAD_MAX  = 10'd504;
  localparam logic [9:0]  PAD_STEP = 10'd4;
  localparam logic [9:0]  SPEED    = 10'd2;
  localparam logic [9:0]  Y_TOP    = 10'd2;
  localparam logic [9:0]  Y_BOT    = 10'd590;
  localparam logic [9:0]  X_LEFT   = 10'd40;
  localparam logic [9:0]  X_MISS   = 10'd792;
  localparam rgb_t C_BLACK = 12'h000;
  localparam rgb_t C_BLUE  = 12'h00F;
  localparam rgb_t C_GREEN = 12'h0F0;
  localparam rgb_t C_RED   = 12'hF00;
endpackage

// File: rtl/pong_pixel_gen_frame_tick.sv
// frame_tick_gen: one-clk pulse on each Vsync rising edge, suppressed in the first cycle after reset.
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic Vsync,
  output logic frame_tick
);
  logic vs_q, armed;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vs_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      vs_q  <= Vsync;
      armed <= 1'b1;
    end
  // armed blocks a false edge when Vsync is already high as reset releases
  assign frame_tick = Vsync & ~vs_q & armed;
endmodule

// File: rtl/pong_pixel_gen.sv
// pong_pixel_gen: Pong game state (paddle, ball, score) updated per frame, plus registered pixel colour.
module pong_pixel_gen
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic        Vsync,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic [7:0]  score
);
  logic        frame_tick;
  state_t      state, next_state;
  logic [9:0]  ball_x, ball_y, paddle_y, bx_n, by_n, pad_n, bx_mv, by_mv;
  logic        dx_neg, dy_neg, dxn_n, dyn_n, hit, play, restart;
  logic [5:0]  miss_cnt;
  logic [15:0] bx, by, py;
  logic        wall_px, pad_px, ball_px;
  rgb_t        pix;

  frame_tick_gen u_tick (.clk(clk), .reset(reset), .Vsync(Vsync), .frame_tick(frame_tick));

  assign bx = {6'd0, ball_x};
  assign by = {6'd0, ball_y};
  assign py = {6'd0, paddle_y};

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else if (frame_tick) state <= next_state;

  always_comb begin
    next_state = state == IDLE ? ((btn_up || btn_down) ? PLAY : IDLE)
               : state == PLAY ? ((bx_mv > X_MISS) ? MISS : PLAY)
               : (miss_cnt == 6'd63) ? IDLE : MISS;
  end

  // velocity is decided from the current position, then the move uses the new velocity
  always_comb begin
    play    = state == PLAY;
    restart = state == IDLE || (state == MISS && miss_cnt == 6'd63);
    hit     = bx + BALL_EXT >= PAD_L && bx + BALL_EXT <= PAD_R && by + BALL_EXT >= py && by <= py + PAD_EXT;
    dyn_n   = ball_y <= Y_TOP ? 1'b0 : ball_y >= Y_BOT ? 1'b1 : dy_neg;
    dxn_n   = hit ? 1'b1 : ball_x <= X_LEFT ? 1'b0 : dx_neg;
    bx_mv   = dxn_n ? ball_x - SPEED : ball_x + SPEED;
    by_mv   = dyn_n ? ball_y - SPEED : ball_y + SPEED;
    bx_n    = play ? bx_mv : restart ? BALL_X0 : ball_x;
    by_n    = play ? by_mv : restart ? BALL_Y0 : ball_y;
    pad_n   = (btn_up && !btn_down) ? (paddle_y < PAD_STEP ? 10'd0 : paddle_y - PAD_STEP)
            : (btn_down && !btn_up) ? (paddle_y > PAD_MAX - PAD_STEP ? PAD_MAX : paddle_y + PAD_STEP)
            : paddle_y;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ball_x   <= BALL_X0;
      ball_y   <= BALL_Y0;
      dx_neg   <= 1'b0;
      dy_neg   <= 1'b0;
      paddle_y <= PAD_Y0;
      score    <= 8'd0;
      miss_cnt <= 6'd0;
    end else if (frame_tick) begin
      ball_x   <= bx_n;
      ball_y   <= by_n;
      dx_neg   <= play ? dxn_n : restart ? 1'b0 : dx_neg;
      dy_neg   <= play ? dyn_n : restart ? 1'b0 : dy_neg;
      paddle_y <= pad_n;
      miss_cnt <= state == MISS ? miss_cnt + 6'd1 : 6'd0;
      if (play && hit) score <= score + 8'd1;
    end

  always_comb begin
    wall_px = pixel_x >= WALL_L && pixel_x <= WALL_R;
    pad_px  = pixel_x >= PAD_L && pixel_x <= PAD_R && pixel_y >= py && pixel_y <= py + PAD_EXT;
    ball_px = pixel_x >= bx && pixel_x <= bx + BALL_EXT && pixel_y >= by && pixel_y <= by + BALL_EXT;
    pix     = !video_on ? C_BLACK : wall_px ? C_BLUE : pad_px ? C_GREEN : ball_px ? C_RED : C_BLACK;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) {Red, Green, Blue} <= 12'h000;
    else {Red, Green, Blue} <= pix;
endmodule

// File: tb/tb_pong_pixel_gen.sv
// tb_pong_pixel_gen: directed scenarios for reset, pixel colours, paddle, bounces, miss and mid-play reset.
module tb_pong_pixel_gen;
  import pong_pkg::*;
  logic clk = 1'b0, reset = 1'b1, video_on = 1'b0, Vsync = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [15:0] pixel_x = 16'd0, pixel_y = 16'd0;
  logic [3:0] Red, Green, Blue;
  logic [7:0] score;
  int n_cmp = 0, n_bad = 0;

  typedef struct packed {
    state_t     st;
    logic [9:0] x;
    logic [9:0] y;
    logic       dxn;
    logic       dyn;
    logic [9:0] pad;
    logic [7:0] sc;
  } snap_t;
  snap_t s, e;

  // {video_on, pixel_x, pixel_y, expected RGB} with paddle_y=252 and ball at (396,296)
  logic [44:0] pv [17] = '{
    {1'b1, 16'd100, 16'd100, 12'h000}, {1'b1, 16'd400, 16'd300, 12'hF00},
    {1'b1, 16'd396, 16'd296, 12'hF00}, {1'b1, 16'd403, 16'd303, 12'hF00},
    {1'b1, 16'd404, 16'd300, 12'h000}, {1'b1, 16'd400, 16'd304, 12'h000},
    {1'b1, 16'd35,  16'd10,  12'h00F}, {1'b1, 16'd39,  16'd599, 12'h00F},
    {1'b1, 16'd40,  16'd0,   12'h000}, {1'b1, 16'd763, 16'd252, 12'h0F0},
    {1'b1, 16'd767, 16'd347, 12'h0F0}, {1'b1, 16'd763, 16'd348, 12'h000},
    {1'b1, 16'd763, 16'd251, 12'h000}, {1'b0, 16'd35,  16'd10,  12'h000},
    {1'b0, 16'd400, 16'd300, 12'h000}, {1'b0, 16'd900, 16'd700, 12'h000},
    {1'b1, 16'd768, 16'd300, 12'h000}
  };

  pong_pixel_gen dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .Vsync(Vsync), .btn_up(btn_up), .btn_down(btn_down),
    .Red(Red), .Green(Green), .Blue(Blue), .score(score)
  );

  always #5 clk = ~clk;

  function automatic snap_t snap();
    return '{dut.state, dut.ball_x, dut.ball_y, dut.dx_neg, dut.dy_neg, dut.paddle_y, score};
  endfunction

  function automatic snap_t mk(state_t st, int x, int y, bit dxn, bit dyn, int pad, int sc);
    return '{st, 10'(x), 10'(y), dxn, dyn, 10'(pad), 8'(sc)};
  endfunction

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) Vsync = 1'b1;
      @(negedge clk);
      @(negedge clk) Vsync = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    Vsync = 1'b1;
    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    s = snap(); e = mk(IDLE, 396, 296, 0, 0, 252, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL reset_state: got %p want %p", s, e); end
    n_cmp++;
    if ({Red, Green, Blue} !== 12'h000) begin n_bad++; $display("FAIL reset_rgb: got %h want 000", {Red, Green, Blue}); end
    reset = 1'b0;
    #1 n_cmp++;
    if (dut.frame_tick !== 1'b0) begin n_bad++; $display("FAIL no_tick_after_release: got %b want 0", dut.frame_tick); end
    repeat (3) @(negedge clk);
    s = snap(); e = mk(IDLE, 396, 296, 0, 0, 252, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL held_vsync_no_tick: got %p want %p", s, e); end
    Vsync = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic test_pixels();
    foreach (pv[i]) begin
      @(negedge clk) {video_on, pixel_x, pixel_y} = pv[i][44:12];
      @(negedge clk) n_cmp++;
      if ({Red, Green, Blue} !== pv[i][11:0])
        begin n_bad++; $display("FAIL pixel_%0d (%0d,%0d,v=%b): got %h want %h", i, pixel_x, pixel_y, video_on, {Red, Green, Blue}, pv[i][11:0]); end
    end
    {video_on, pixel_x, pixel_y} = {1'b1, 16'd35, 16'd10};
    #1 n_cmp++;
    if ({Red, Green, Blue} !== 12'h000) begin n_bad++; $display("FAIL rgb_latency_early: got %h want 000", {Red, Green, Blue}); end
    @(negedge clk) n_cmp++;
    if ({Red, Green, Blue} !== 12'h00F) begin n_bad++; $display("FAIL rgb_latency_late: got %h want 00f", {Red, Green, Blue}); end
    video_on = 1'b0;
  endtask

  task automatic test_paddle_start();
    btn_down = 1'b1;
    frames(1);
    s = snap(); e = mk(PLAY, 396, 296, 0, 0, 256, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL start_tick1: got %p want %p", s, e); end
    frames(9);
    s = snap(); e = mk(PLAY, 414, 314, 0, 0, 292, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL start_tick10: got %p want %p", s, e); end
    frames(53);
    s = snap(); e = mk(PLAY, 520, 420, 0, 0, 504, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL paddle_reach_max: got %p want %p", s, e); end
    frames(5);
    s = snap(); e = mk(PLAY, 530, 430, 0, 0, 504, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL paddle_clamp_max: got %p want %p", s, e); end
    btn_down = 1'b0;
  endtask

  task automatic test_paddle_hit();
    frames(111);
    s = snap(); e = mk(PLAY, 752, 528, 0, 1, 504, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL approach_752: got %p want %p", s, e); end
    frames(1);
    s = snap(); e = mk(PLAY, 754, 526, 0, 1, 504, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL approach_754: got %p want %p", s, e); end
    @(negedge clk) {video_on, pixel_x, pixel_y} = {1'b1, 16'd760, 16'd527};
    @(negedge clk) n_cmp++;
    if ({Red, Green, Blue} !== 12'h0F0) begin n_bad++; $display("FAIL paddle_over_ball: got %h want 0f0", {Red, Green, Blue}); end
    pixel_x = 16'd758;
    @(negedge clk) n_cmp++;
    if ({Red, Green, Blue} !== 12'hF00) begin n_bad++; $display("FAIL ball_near_paddle: got %h want f00", {Red, Green, Blue}); end
    pixel_x = 16'd753;
    @(negedge clk) n_cmp++;
    if ({Red, Green, Blue} !== 12'h000) begin n_bad++; $display("FAIL left_of_ball: got %h want 000", {Red, Green, Blue}); end
    video_on = 1'b0;
    frames(1);
    s = snap(); e = mk(PLAY, 752, 524, 1, 1, 504, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL paddle_hit: got %p want %p", s, e); end
  endtask

  task automatic test_bounces();
    frames(261);
    s = snap(); e = mk(PLAY, 230, 2, 1, 1, 504, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL reach_top: got %p want %p", s, e); end
    frames(1);
    s = snap(); e = mk(PLAY, 228, 4, 1, 0, 504, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL top_bounce: got %p want %p", s, e); end
    frames(94);
    s = snap(); e = mk(PLAY, 40, 192, 1, 0, 504, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL reach_wall: got %p want %p", s, e); end
    frames(1);
    s = snap(); e = mk(PLAY, 42, 194, 0, 0, 504, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL wall_bounce: got %p want %p", s, e); end
  endtask

  task automatic test_miss();
    btn_up = 1'b1;
    frames(375);
    s = snap(); e = mk(PLAY, 792, 236, 0, 1, 0, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL before_miss: got %p want %p", s, e); end
    frames(1);
    s = snap(); e = mk(MISS, 794, 234, 0, 1, 0, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL enter_miss: got %p want %p", s, e); end
    btn_up = 1'b0;
    frames(63);
    s = snap(); e = mk(MISS, 794, 234, 0, 1, 0, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL miss_63_ticks: got %p want %p", s, e); end
    frames(1);
    s = snap(); e = mk(IDLE, 396, 296, 0, 0, 0, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL miss_to_idle: got %p want %p", s, e); end
  endtask

  task automatic test_reset_mid_play();
    btn_down = 1'b1;
    frames(2);
    s = snap(); e = mk(PLAY, 398, 298, 0, 0, 8, 1); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL restart_play: got %p want %p", s, e); end
    @(negedge clk) {video_on, pixel_x, pixel_y} = {1'b1, 16'd35, 16'd10};
    @(negedge clk) n_cmp++;
    if ({Red, Green, Blue} !== 12'h00F) begin n_bad++; $display("FAIL pre_reset_rgb: got %h want 00f", {Red, Green, Blue}); end
    Vsync = 1'b1;
    #2 reset = 1'b1;
    #1 s = snap(); e = mk(IDLE, 396, 296, 0, 0, 252, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL async_reset_state: got %p want %p", s, e); end
    n_cmp++;
    if ({Red, Green, Blue, dut.frame_tick} !== 13'h0) begin n_bad++; $display("FAIL async_reset_rgb_tick: got %h want 0", {Red, Green, Blue, dut.frame_tick}); end
    @(negedge clk) reset = 1'b0;
    #1 n_cmp++;
    if (dut.frame_tick !== 1'b0) begin n_bad++; $display("FAIL mid_release_tick: got %b want 0", dut.frame_tick); end
    repeat (3) @(negedge clk);
    s = snap(); e = mk(IDLE, 396, 296, 0, 0, 252, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL mid_release_hold: got %p want %p", s, e); end
    Vsync = 1'b0;
    frames(1);
    s = snap(); e = mk(PLAY, 396, 296, 0, 0, 256, 0); n_cmp++;
    if (s !== e) begin n_bad++; $display("FAIL next_edge_tick: got %p want %p", s, e); end
    btn_down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_paddle_start();
    test_paddle_hit();
    test_bounces();
    test_miss();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
